// File: rtl/daq_frame_packer.sv
// daq_frame_packer
//   Wraps each readout (StartReadout ... EndReadout) of the Microroc word stream into a frame:
//   HEADER_WORD, event number, stored payload, word count, [CRC], TRAILER_WORD. Frames go
//   through an internal FIFO (16 data bits + last-tag bit) and drain into the USB FIFO
//   under back-pressure.
//
// Ports
//   Clk, reset        : clock and asynchronous active-high reset
//   StartReadout      : one-cycle pulse opening a frame (ignored unless idle)
//   EndReadout        : one-cycle pulse closing a frame
//   DaqData/_en       : payload word and its valid strobe
//   UsbFifoFull       : USB FIFO almost-full (at least one word of slack)
//   UsbFifoData/_en   : registered word and one-cycle write strobe to the USB FIFO
//   DataTransmitDone  : pulses with the strobe that carries a trailer
//   Overflow          : sticky, set when any payload word has been dropped
//   EventCount        : event number of the open (or next) frame
//
// Build option
//   FRAME_CRC_EN : when defined, a CRC-16/CCITT word (poly 0x1021, init 0xFFFF, MSB first,
//                  no final XOR) over the stored payload is inserted between count and trailer.
module daq_frame_packer #(
    parameter logic [15:0] HEADER_WORD  = 16'hA5A5,
    parameter logic [15:0] TRAILER_WORD = 16'h5A5A,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        StartReadout,
    input  logic        EndReadout,
    input  logic [15:0] DaqData,
    input  logic        DaqData_en,
    input  logic        UsbFifoFull,
    output logic [15:0] UsbFifoData,
    output logic        UsbFifoData_en,
    output logic        DataTransmitDone,
    output logic        Overflow,
    output logic [15:0] EventCount
);

    localparam int unsigned Depth = 2 ** FIFO_AW;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StEvt,
        StPayload,
        StCnt,
`ifdef FRAME_CRC_EN
        StCrc,
`endif
        StTrl
    } wrState_e;

    wrState_e         state_q;
    logic [15:0]      wordCount_q;
    logic             endLatched_q;
    logic [FIFO_AW:0] wrPtr_q, rdPtr_q;
    logic [16:0]      fifoMem [Depth];

    logic        fifoEmpty, fifoFull, pop, canPush, pushReq, push;
    logic [16:0] pushData;

`ifdef FRAME_CRC_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crcStep(input logic [15:0] crcIn, input logic [15:0] data);
        logic [15:0] c;
        c = crcIn;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Extra pointer bit separates full from empty.
    always_comb begin
        fifoEmpty = (wrPtr_q == rdPtr_q);
        fifoFull  = (wrPtr_q[FIFO_AW] != rdPtr_q[FIFO_AW]) &&
                    (wrPtr_q[FIFO_AW-1:0] == rdPtr_q[FIFO_AW-1:0]);
        pop       = !fifoEmpty && !UsbFifoFull;
        // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
        canPush   = !fifoFull || pop;
    end

    always_comb begin
        pushReq  = 1'b0;
        pushData = 17'd0;
        unique case (state_q)
            StHdr:     begin pushReq = 1'b1;       pushData = {1'b0, HEADER_WORD};  end
            StEvt:     begin pushReq = 1'b1;       pushData = {1'b0, EventCount};   end
            StPayload: begin pushReq = DaqData_en; pushData = {1'b0, DaqData};      end
            StCnt:     begin pushReq = 1'b1;       pushData = {1'b0, wordCount_q};  end
`ifdef FRAME_CRC_EN
            StCrc:     begin pushReq = 1'b1;       pushData = {1'b0, crc_q};        end
`endif
            StTrl:     begin pushReq = 1'b1;       pushData = {1'b1, TRAILER_WORD}; end
            default:   ;
        endcase
        push = pushReq && canPush;
    end

    // Write-side FSM; control-word states simply hold until the FIFO accepts.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wordCount_q  <= 16'd0;
            endLatched_q <= 1'b0;
            EventCount   <= 16'd0;
            Overflow     <= 1'b0;
`ifdef FRAME_CRC_EN
            crc_q        <= 16'hFFFF;
`endif
        end else begin
            // Any valid word that is not stored is a drop.
            if (DaqData_en && !((state_q == StPayload) && canPush)) Overflow <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (StartReadout) begin
                        state_q      <= StHdr;
                        wordCount_q  <= 16'd0;
                        endLatched_q <= 1'b0;
`ifdef FRAME_CRC_EN
                        crc_q        <= 16'hFFFF;
`endif
                    end
                end
                StHdr: begin
                    if (EndReadout) endLatched_q <= 1'b1;
                    if (canPush) state_q <= StEvt;
                end
                StEvt: begin
                    if (EndReadout) endLatched_q <= 1'b1;
                    if (canPush) state_q <= (endLatched_q || EndReadout) ? StCnt : StPayload;
                end
                StPayload: begin
                    if (push) begin
                        if (wordCount_q != 16'hFFFF) wordCount_q <= wordCount_q + 16'd1;
`ifdef FRAME_CRC_EN
                        crc_q <= crcStep(crc_q, DaqData);
`endif
                    end
                    if (EndReadout) state_q <= StCnt;
                end
                StCnt: begin
`ifdef FRAME_CRC_EN
                    if (canPush) state_q <= StCrc;
`else
                    if (canPush) state_q <= StTrl;
`endif
                end
`ifdef FRAME_CRC_EN
                StCrc: begin
                    if (canPush) state_q <= StTrl;
                end
`endif
                StTrl: begin
                    if (canPush) begin
                        state_q    <= StIdle;
                        EventCount <= EventCount + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (push) wrPtr_q <= wrPtr_q + (FIFO_AW + 1)'(1);
            if (pop)  rdPtr_q <= rdPtr_q + (FIFO_AW + 1)'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge Clk) begin
        if (push) fifoMem[wrPtr_q[FIFO_AW-1:0]] <= pushData;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            UsbFifoData      <= 16'd0;
            UsbFifoData_en   <= 1'b0;
            DataTransmitDone <= 1'b0;
        end else begin
            UsbFifoData_en   <= pop;
            DataTransmitDone <= pop && fifoMem[rdPtr_q[FIFO_AW-1:0]][16];
            if (pop) UsbFifoData <= fifoMem[rdPtr_q[FIFO_AW-1:0]][15:0];
        end
    end

endmodule
